// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART bus master: command/response bytes,
// command FSM state encoding and the default parking address.
package uart_bus_pkg;

    localparam logic [7:0] OP_W  = 8'h57;   // 'W' write command
    localparam logic [7:0] OP_R  = 8'h52;   // 'R' read command
    localparam logic [7:0] RSP_K = 8'h4B;   // 'K' write acknowledge
    localparam logic [7:0] RSP_E = 8'h45;   // 'E' read timeout
    localparam logic [7:0] RSP_Q = 8'h3F;   // '?' unknown opcode

    localparam logic [31:0] PARK_ADDR_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_WR     = 3'd3,
        ST_RD     = 3'd4,
        ST_RDWAIT = 3'd5,
        ST_RESP   = 3'd6
    } state_e;

    // Receive path is open only while a command is being collected.
    function automatic logic rx_open(input state_e s);
        return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/uart_bus_txser.sv
// Response serializer: loads a 1-byte or 4-byte (MSB first) reply and
// presents it on the transmit AXI-stream, one byte per handshake.
// done is asserted combinationally on the handshake of the final byte.
module uart_bus_txser
    import uart_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        four,
    input  logic [31:0] word,
    input  logic        tx_tready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    output logic        done
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  left_q,  left_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        hs_s;

    assign hs_s      = tvalid_q & tx_tready;
    assign done      = hs_s & (left_q == 2'd0);
    assign tx_tdata  = tdata_q;
    assign tx_tvalid = tvalid_q;

    // Next-state: load a new reply, or advance to the next byte on handshake.
    always_comb begin
        shift_d  = shift_q;
        left_d   = left_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        if (load) begin
            tvalid_d = 1'b1;
            if (four) begin
                tdata_d = word[31:24];
                shift_d = word[23:0];
                left_d  = 2'd3;
            end else begin
                tdata_d = word[7:0];
                shift_d = 24'h00_0000;
                left_d  = 2'd0;
            end
        end else if (hs_s) begin
            if (left_q != 2'd0) begin
                tdata_d = shift_q[23:16];
                shift_d = {shift_q[15:0], 8'h00};
                left_d  = left_q - 2'd1;
            end else begin
                tvalid_d = 1'b0;
                tdata_d  = 8'h00;
            end
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // Serializer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q  <= 24'h00_0000;
            left_q   <= 2'd0;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            left_q   <= left_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: collects 'W'/'R' commands from the UART receive
// stream, performs one bus write or read on the port-B bus, and returns the
// reply through uart_bus_txser. busy claims the bus mux while a command runs.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter logic [31:0] PARK_ADDR    = PARK_ADDR_DEFAULT,
    parameter int          RD_TIMEOUT   = 16,
    parameter int          BYTE_TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [31:0] m_we,
    input  logic [31:0] m_rdata,
    input  logic        m_strobe,
    output logic        busy
);

    localparam int RD_W = $clog2(RD_TIMEOUT + 1);
    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [RD_W-1:0] RD_LAST  = RD_W'(RD_TIMEOUT - 1);
    localparam logic [BT_W-1:0] BT_LIMIT = BT_W'(BYTE_TIMEOUT);

    state_e            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [RD_W-1:0]   tmo_q, tmo_d;
    logic [BT_W-1:0]   bto_q, bto_d;
    logic [31:0]       m_addr_q, m_addr_d;
    logic [31:0]       m_wdata_q, m_wdata_d;
    logic [31:0]       m_we_q, m_we_d;
    logic              rx_tready_q, rx_tready_d;
    logic              busy_q, busy_d;

    logic              accept_s;
    logic              bto_expired_s;
    logic              tx_load_s;
    logic              tx_four_s;
    logic [31:0]       tx_word_s;
    logic              tx_done_s;

    assign accept_s      = rx_tvalid & rx_tready_q;
    assign bto_expired_s = (bto_q == BT_LIMIT);

    assign rx_tready = rx_tready_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_we      = m_we_q;
    assign busy      = busy_q;

    uart_bus_txser u_txser (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load_s),
        .four      (tx_four_s),
        .word      (tx_word_s),
        .tx_tready (tx_tready),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .done      (tx_done_s)
    );

    // Command FSM next-state, field shifting, counters and bus drive.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_we_d    = m_we_q;
        tx_load_s = 1'b0;
        tx_four_s = 1'b0;
        tx_word_s = 32'h0000_0000;

        // Inter-byte silence counter: cleared per accepted byte, saturating.
        if (accept_s) begin
            bto_d = {BT_W{1'b0}};
        end else if (!bto_expired_s) begin
            bto_d = bto_q + BT_W'(1);
        end else begin
            bto_d = bto_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d  = rx_tdata;
                    cnt_d = 2'd0;
                    if ((rx_tdata == OP_W) || (rx_tdata == OP_R)) begin
                        state_d = ST_ADDR;
                    end else begin
                        tx_load_s = 1'b1;
                        tx_word_s = {24'h00_0000, RSP_Q};
                        state_d   = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (accept_s) begin
                    addr_d = {addr_q[23:0], rx_tdata};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (op_q == OP_W) begin
                            state_d = ST_DATA;
                        end else begin
                            m_addr_d = {addr_q[23:0], rx_tdata};
                            m_we_d   = 32'd0;
                            tmo_d    = {RD_W{1'b0}};
                            state_d  = ST_RD;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else if (bto_expired_s) begin
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    data_d = {data_q[23:0], rx_tdata};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        m_addr_d  = addr_q;
                        m_wdata_d = {data_q[23:0], rx_tdata};
                        m_we_d    = 32'd1;
                        state_d   = ST_WR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (bto_expired_s) begin
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WR: begin
                // Write is a single cycle; any responder strobe is ignored.
                m_addr_d  = PARK_ADDR;
                m_we_d    = 32'd0;
                tx_load_s = 1'b1;
                tx_word_s = {24'h00_0000, RSP_K};
                state_d   = ST_RESP;
            end
            ST_RD, ST_RDWAIT: begin
                // A strobe on the last allowed cycle still returns data.
                if (m_strobe) begin
                    m_addr_d  = PARK_ADDR;
                    tx_load_s = 1'b1;
                    tx_four_s = 1'b1;
                    tx_word_s = m_rdata;
                    state_d   = ST_RESP;
                end else if (tmo_q == RD_LAST) begin
                    m_addr_d  = PARK_ADDR;
                    tx_load_s = 1'b1;
                    tx_word_s = {24'h00_0000, RSP_E};
                    state_d   = ST_RESP;
                end else begin
                    tmo_d   = tmo_q + RD_W'(1);
                    state_d = ST_RDWAIT;
                end
            end
            ST_RESP: begin
                if (tx_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                m_addr_d = PARK_ADDR;
                m_we_d   = 32'd0;
                state_d  = ST_IDLE;
            end
        endcase

        rx_tready_d = rx_open(state_d);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 8'h00;
            addr_q      <= 32'h0000_0000;
            data_q      <= 32'h0000_0000;
            cnt_q       <= 2'd0;
            tmo_q       <= {RD_W{1'b0}};
            bto_q       <= {BT_W{1'b0}};
            m_addr_q    <= PARK_ADDR;
            m_wdata_q   <= 32'h0000_0000;
            m_we_q      <= 32'd0;
            rx_tready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            bto_q       <= bto_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_we_q      <= m_we_d;
            rx_tready_q <= rx_tready_d;
            busy_q      <= busy_d;
        end
    end

endmodule
